// File: rtl/axis_proc_pkg.sv
// Shared definitions for the AXI-Stream processing FIFO and the sources that feed it:
// processing-mode encodings, arbiter state encoding and the default stream width.
package axis_proc_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;

  localparam logic [1:0] MODE_PASS  = 2'b00;
  localparam logic [1:0] MODE_BSWAP = 2'b01;
  localparam logic [1:0] MODE_ADD   = 2'b10;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first requester strictly after last_grant
// (wrapping) wins; returns both a one-hot grant and its index, all-zero when idle.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant_oh,
  output logic [IDX_W-1:0]   grant_idx
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;
  logic             hit;
  logic             found;

  // Scan candidates in priority order; once one hits, later ones are masked off.
  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    cand      = 0;
    cand_idx  = '0;
    hit       = 1'b0;
    found     = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand           = (int'(last_grant) + i) % NUM_REQ;
      cand_idx       = IDX_W'(cand);
      hit            = req[cand_idx] & ~found;
      grant_oh[cand_idx] = hit;
      grant_idx      = hit ? cand_idx : grant_idx;
      found          = found | hit;
    end
  end

endmodule

// File: rtl/axis_packet_arbiter.sv
// Packet-granular round-robin arbiter in front of the processing FIFO: one source owns
// the stream from grant through its tlast beat, with its mode/add_value frozen meanwhile.
module axis_packet_arbiter
  import axis_proc_pkg::*;
#(
  parameter int  DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int  NUM_SRC    = 4,
  localparam int BYTES      = DATA_WIDTH / 8,
  localparam int IDX_W      = $clog2(NUM_SRC)
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic [NUM_SRC-1:0]            s_axis_tvalid,
  output logic [NUM_SRC-1:0]            s_axis_tready,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_SRC*BYTES-1:0]      s_axis_tkeep,
  input  logic [NUM_SRC*BYTES-1:0]      s_axis_tstrb,
  input  logic [NUM_SRC-1:0]            s_axis_tlast,
  input  logic [NUM_SRC*2-1:0]          src_mode,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_add_value,
  output logic                          m_axis_tvalid,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic [BYTES-1:0]              m_axis_tkeep,
  output logic [BYTES-1:0]              m_axis_tstrb,
  output logic                          m_axis_tlast,
  input  logic                          m_axis_tready,
  output logic [1:0]                    mode,
  output logic [DATA_WIDTH-1:0]         add_value,
  output logic [IDX_W-1:0]              grant_idx,
  output logic                          busy,
  output logic                          pkt_done
);

  localparam int MODE_W = 2;

  arb_state_e             state_q, state_d;
  logic [IDX_W-1:0]       grant_idx_q, grant_idx_d;
  logic [IDX_W-1:0]       last_grant_q, last_grant_d;
  logic [1:0]             mode_q, mode_d;
  logic [DATA_WIDTH-1:0]  add_value_q, add_value_d;
  logic                   pkt_done_q, pkt_done_d;
  logic [NUM_SRC-1:0]     arb_oh;
  logic [IDX_W-1:0]       arb_idx;
  logic                   in_xfer;
  logic                   last_hs;

  rr_arbiter #(
    .NUM_REQ (NUM_SRC),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req        (s_axis_tvalid),
    .last_grant (last_grant_q),
    .grant_oh   (arb_oh),
    .grant_idx  (arb_idx)
  );

  assign in_xfer = (state_q == ST_XFER);

  // Zero-latency pass-through of the granted source; everything is quiet outside XFER.
  always_comb begin
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tstrb  = '0;
    m_axis_tlast  = 1'b0;
    s_axis_tready = '0;
    if (in_xfer) begin
      m_axis_tvalid              = s_axis_tvalid[grant_idx_q];
      m_axis_tdata               = s_axis_tdata[grant_idx_q*DATA_WIDTH +: DATA_WIDTH];
      m_axis_tkeep               = s_axis_tkeep[grant_idx_q*BYTES +: BYTES];
      m_axis_tstrb               = s_axis_tstrb[grant_idx_q*BYTES +: BYTES];
      m_axis_tlast               = s_axis_tlast[grant_idx_q];
      s_axis_tready[grant_idx_q] = m_axis_tready;
    end else begin
      s_axis_tready = '0;
    end
  end

  assign last_hs = in_xfer & m_axis_tvalid & m_axis_tready & m_axis_tlast;

  // Grant on any request in IDLE; release only on the tlast handshake, so stalls hold the grant.
  always_comb begin
    state_d      = state_q;
    grant_idx_d  = grant_idx_q;
    last_grant_d = last_grant_q;
    mode_d       = mode_q;
    add_value_d  = add_value_q;
    pkt_done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|arb_oh) begin
          state_d     = ST_XFER;
          grant_idx_d = arb_idx;
          mode_d      = src_mode[arb_idx*MODE_W +: MODE_W];
          add_value_d = src_add_value[arb_idx*DATA_WIDTH +: DATA_WIDTH];
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_XFER: begin
        if (last_hs) begin
          state_d      = ST_IDLE;
          pkt_done_d   = 1'b1;
          last_grant_d = grant_idx_q;
        end else begin
          state_d = ST_XFER;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and latched configuration; last_grant resets to the top index so source 0 wins first.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q      <= ST_IDLE;
      grant_idx_q  <= '0;
      last_grant_q <= IDX_W'(NUM_SRC - 1);
      mode_q       <= MODE_PASS;
      add_value_q  <= '0;
      pkt_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_idx_q  <= grant_idx_d;
      last_grant_q <= last_grant_d;
      mode_q       <= mode_d;
      add_value_q  <= add_value_d;
      pkt_done_q   <= pkt_done_d;
    end
  end

  assign mode      = mode_q;
  assign add_value = add_value_q;
  assign grant_idx = grant_idx_q;
  assign busy      = in_xfer;
  assign pkt_done  = pkt_done_q;

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Scoreboard bench for axis_packet_arbiter: per-source beat queues drive the inputs and
// expected output beats are queued in predicted grant order, then popped on each m_axis handshake.
module tb_axis_packet_arbiter;

  localparam int DW = 32;
  localparam int N  = 4;
  localparam int BY = DW / 8;

  typedef struct {
    logic [DW-1:0] data;
    logic [BY-1:0] keep;
    logic          last;
  } beat_t;

  typedef struct {
    int            src;
    logic [DW-1:0] data;
    logic [BY-1:0] keep;
    logic          last;
    logic [1:0]    mode;
    logic [DW-1:0] add;
  } exp_t;

  logic            aclk;
  logic            areset;
  logic [N-1:0]    s_axis_tvalid;
  logic [N-1:0]    s_axis_tready;
  logic [N*DW-1:0] s_axis_tdata;
  logic [N*BY-1:0] s_axis_tkeep;
  logic [N*BY-1:0] s_axis_tstrb;
  logic [N-1:0]    s_axis_tlast;
  logic [N*2-1:0]  src_mode;
  logic [N*DW-1:0] src_add_value;
  logic            m_axis_tvalid;
  logic [DW-1:0]   m_axis_tdata;
  logic [BY-1:0]   m_axis_tkeep;
  logic [BY-1:0]   m_axis_tstrb;
  logic            m_axis_tlast;
  logic            m_axis_tready;
  logic [1:0]      mode;
  logic [DW-1:0]   add_value;
  logic [1:0]      grant_idx;
  logic            busy;
  logic            pkt_done;

  beat_t      src_q [N][$];
  exp_t       exp_q [$];
  int         done_cyc [$];
  logic [N-1:0] src_hold;
  int         errors;
  int         checks;
  int         cyc;
  int         pkt_cnt;

  axis_packet_arbiter #(.DATA_WIDTH(DW), .NUM_SRC(N)) dut (
    .aclk          (aclk),
    .areset        (areset),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tstrb  (s_axis_tstrb),
    .s_axis_tlast  (s_axis_tlast),
    .src_mode      (src_mode),
    .src_add_value (src_add_value),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tstrb  (m_axis_tstrb),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .mode          (mode),
    .add_value     (add_value),
    .grant_idx     (grant_idx),
    .busy          (busy),
    .pkt_done      (pkt_done)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic drive_srcs();
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0 && !src_hold[i]) begin
        s_axis_tvalid[i]           = 1'b1;
        s_axis_tdata[i*DW +: DW]   = src_q[i][0].data;
        s_axis_tkeep[i*BY +: BY]   = src_q[i][0].keep;
        s_axis_tstrb[i*BY +: BY]   = src_q[i][0].keep;
        s_axis_tlast[i]            = src_q[i][0].last;
      end else begin
        s_axis_tvalid[i]           = 1'b0;
        s_axis_tdata[i*DW +: DW]   = '0;
        s_axis_tkeep[i*BY +: BY]   = '0;
        s_axis_tstrb[i*BY +: BY]   = '0;
        s_axis_tlast[i]            = 1'b0;
      end
    end
  endtask

  task automatic push_beat(input int src, input logic [DW-1:0] data, input logic [BY-1:0] keep,
                           input logic last);
    beat_t b;
    exp_t  e;
    b.data = data; b.keep = keep; b.last = last;
    src_q[src].push_back(b);
    e.src  = src; e.data = data; e.keep = keep; e.last = last;
    e.mode = src_mode[src*2 +: 2];
    e.add  = src_add_value[src*DW +: DW];
    exp_q.push_back(e);
  endtask

  task automatic push_pkt(input int src, input int n, input logic [DW-1:0] base);
    for (int k = 0; k < n; k++)
      push_beat(src, base + DW'(k), (k == n - 1) ? 4'h3 : 4'hF, k == n - 1);
  endtask

  // One clock: sample mid-cycle, score any m_axis beat, then advance the source models.
  task automatic tick();
    logic [N-1:0] hs;
    exp_t e;
    @(negedge aclk);
    hs = s_axis_tvalid & s_axis_tready;
    if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL beat_unexpected: got data=%h grant=%0d, required no beat", m_axis_tdata, grant_idx);
      end else begin
        e = exp_q.pop_front();
        if (m_axis_tdata !== e.data || m_axis_tlast !== e.last || m_axis_tkeep !== e.keep ||
            m_axis_tstrb !== e.keep || grant_idx !== 2'(e.src) || mode !== e.mode || add_value !== e.add) begin
          errors++;
          $display("FAIL beat: got src=%0d data=%h keep=%h strb=%h last=%b mode=%b add=%h, required src=%0d data=%h keep=%h last=%b mode=%b add=%h",
                   grant_idx, m_axis_tdata, m_axis_tkeep, m_axis_tstrb, m_axis_tlast, mode, add_value,
                   e.src, e.data, e.keep, e.last, e.mode, e.add);
        end
        if (e.last) done_cyc.push_back(cyc);
      end
    end
    @(posedge aclk);
    #1;
    cyc++;
    for (int i = 0; i < N; i++)
      if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    if (pkt_done === 1'b1) pkt_cnt++;
    drive_srcs();
  endtask

  task automatic drain(input int bound, output int n);
    n = 0;
    while ((exp_q.size() > 0 || busy === 1'b1) && n < bound) begin
      tick();
      n++;
    end
    if (n >= bound) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d beats left after %0d cycles, required 0", exp_q.size(), n);
    end
  endtask

  task automatic test_reset();
    areset = 1'b1;
    @(posedge aclk);
    #1;
    tick();
    tick();
    checks++;
    if ({busy, pkt_done, m_axis_tvalid, s_axis_tready, grant_idx, mode, add_value,
         m_axis_tdata, m_axis_tkeep, m_axis_tstrb, m_axis_tlast} !== '0) begin
      errors++;
      $display("FAIL reset_values: busy=%b done=%b mvalid=%b srdy=%b grant=%0d mode=%b add=%h data=%h, required all 0",
               busy, pkt_done, m_axis_tvalid, s_axis_tready, grant_idx, mode, add_value, m_axis_tdata);
    end
    areset = 1'b0;
  endtask

  task automatic test_contention();
    int n;
    int p0;
    src_mode      = {2'b10, 2'b00, 2'b01, 2'b10};
    src_add_value = {32'h0000_0307, 32'h0000_0207, 32'h0000_0107, 32'h0000_0007};
    push_pkt(0, 2, 32'h0A00_0000);
    push_pkt(1, 2, 32'h1A00_0000);
    push_pkt(2, 2, 32'h2A00_0000);
    push_pkt(3, 2, 32'h3A00_0000);
    push_pkt(0, 2, 32'h0B00_0000);
    drive_srcs();
    p0 = pkt_cnt;
    drain(100, n);
    checks++;
    if (n !== 15) begin
      errors++;
      $display("FAIL contention_cycles: got %0d, required 15", n);
    end
    tick();
    checks++;
    if (pkt_cnt - p0 !== 5) begin
      errors++;
      $display("FAIL contention_pkt_done: got %0d, required 5", pkt_cnt - p0);
    end
  endtask

  task automatic test_single();
    int n;
    int p0;
    src_mode[3:2] = 2'b01;
    push_beat(1, 32'hDEADBEEF, 4'hF, 1'b0);
    push_beat(1, 32'h12345678, 4'hF, 1'b0);
    push_beat(1, 32'hABCDEF01, 4'hF, 1'b1);
    drive_srcs();
    p0 = pkt_cnt;
    drain(50, n);
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL single_cycles: got %0d, required 4", n);
    end
    tick();
    checks++;
    if (pkt_cnt - p0 !== 1) begin
      errors++;
      $display("FAIL single_pkt_done: got %0d, required 1", pkt_cnt - p0);
    end
  endtask

  task automatic test_backpressure();
    int n;
    logic [N-1:0] exp_rdy;
    push_pkt(2, 4, 32'h5500_0000);
    push_pkt(3, 1, 32'h6600_0000);
    m_axis_tready = 1'b1;
    drive_srcs();
    tick();
    checks++;
    if (grant_idx !== 2'd2 || busy !== 1'b1) begin
      errors++;
      $display("FAIL bp_grant: got grant=%0d busy=%b, required 2/1", grant_idx, busy);
    end
    for (int c = 0; c < 8; c++) begin
      m_axis_tready = (c % 2 == 1);
      exp_rdy = (c % 2 == 1) ? 4'b0100 : 4'b0000;
      #1;
      checks++;
      if (s_axis_tready !== exp_rdy || busy !== 1'b1) begin
        errors++;
        $display("FAIL bp_ready c=%0d: got srdy=%b busy=%b, required %b/1", c, s_axis_tready, busy, exp_rdy);
      end
      tick();
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_length: got busy=%b after 8 cycles, required 0", busy);
    end
    m_axis_tready = 1'b1;
    drain(50, n);
  endtask

  task automatic test_config_lock();
    int n;
    src_mode[7:6]        = 2'b10;
    src_add_value[127:96] = 32'h0000_0001;
    push_pkt(3, 4, 32'h7700_0000);
    drive_srcs();
    tick();
    tick();
    src_mode[7:6]        = 2'b00;
    src_add_value[127:96] = 32'h0000_0055;
    tick();
    checks++;
    if (mode !== 2'b10 || add_value !== 32'h0000_0001) begin
      errors++;
      $display("FAIL config_lock: got mode=%b add=%h, required 10/00000001", mode, add_value);
    end
    drain(50, n);
  endtask

  task automatic test_stall();
    int n;
    src_mode      = {2'b00, 2'b01, 2'b10, 2'b01};
    src_add_value = {32'h0000_0004, 32'h0000_0003, 32'h0000_0002, 32'h0000_0001};
    push_pkt(0, 3, 32'h8800_0000);
    push_pkt(1, 1, 32'h9900_0000);
    src_hold = 4'b0010;
    drive_srcs();
    tick();
    tick();
    src_hold = 4'b0001;
    drive_srcs();
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (grant_idx !== 2'd0 || busy !== 1'b1 || m_axis_tvalid !== 1'b0 || s_axis_tready[1] !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold k=%0d: got grant=%0d busy=%b mvalid=%b srdy=%b, required 0/1/0/xx0x",
                 k, grant_idx, busy, m_axis_tvalid, s_axis_tready);
      end
    end
    src_hold = 4'b0000;
    done_cyc.delete();
    drive_srcs();
    drain(50, n);
    checks++;
    if (done_cyc.size() !== 2) begin
      errors++;
      $display("FAIL stall_packets: got %0d completions, required 2", done_cyc.size());
    end else if (done_cyc[1] - done_cyc[0] !== 2) begin
      errors++;
      $display("FAIL single_beat_bubble: got gap %0d, required 2", done_cyc[1] - done_cyc[0]);
    end
  endtask

  task automatic test_reset_mid();
    src_mode = '0;
    src_add_value = '0;
    push_pkt(1, 4, 32'hC100_0000);
    drive_srcs();
    tick();
    tick();
    tick();
    areset = 1'b1;
    tick();
    for (int i = 0; i < N; i++) src_q[i].delete();
    exp_q.delete();
    drive_srcs();
    #1;
    checks++;
    if ({busy, pkt_done, m_axis_tvalid, s_axis_tready, grant_idx, mode, add_value,
         m_axis_tdata, m_axis_tkeep, m_axis_tstrb, m_axis_tlast} !== '0) begin
      errors++;
      $display("FAIL reset_mid_values: busy=%b done=%b mvalid=%b srdy=%b grant=%0d, required all 0",
               busy, pkt_done, m_axis_tvalid, s_axis_tready, grant_idx);
    end
    tick();
    tick();
    areset = 1'b0;
    push_pkt(2, 1, 32'hD200_0000);
    drive_srcs();
    tick();
    checks++;
    if (grant_idx !== 2'd2 || busy !== 1'b1 || m_axis_tvalid !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_grant: got grant=%0d busy=%b mvalid=%b, required 2/1/1", grant_idx, busy, m_axis_tvalid);
    end
    tick();
    checks++;
    if (pkt_done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_done: got pkt_done=%b busy=%b, required 1/0", pkt_done, busy);
    end
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    cyc           = 0;
    pkt_cnt       = 0;
    src_hold      = '0;
    areset        = 1'b1;
    m_axis_tready = 1'b1;
    src_mode      = '0;
    src_add_value = '0;
    s_axis_tvalid = '0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tstrb  = '0;
    s_axis_tlast  = '0;
    test_reset();
    test_contention();
    test_single();
    test_backpressure();
    test_config_lock();
    test_stall();
    test_reset_mid();
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL leftover_beats: got %0d, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
